seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits (legal values 8, 16, 32).
REQ-002 The block SHALL have localparam SHW = clog2(WIDTH), the width of the shift-amount field.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operation request is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept a request this cycle.
REQ-007 The block SHALL have port alu_op, input, 4 bits: operation code, decoded per REQ-013.
REQ-008 The block SHALL have ports alu_a and alu_b, input, WIDTH bits each: the operands.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result and flags are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer takes the result this cycle.
REQ-011 The block SHALL have port alu_result, output, WIDTH bits: the result.
REQ-012 The block SHALL have ports z, v, n, c and err, output, 1 bit each: zero, signed overflow, negative, carry/borrow and illegal-op flags.

Function
REQ-013 Opcodes SHALL decode as follows:
- 0 ADD: a+b
- 1 SUB: a-b
- 2 NAND: ~(a&b)
- 3 XOR: a^b
- 4 INC: a+1 (b ignored)
- 5 SRA: arithmetic shift right
- 6 SRL: logical shift right
- 7 SLL: shift left
- 8 ROL: rotate left
- 9 ROR: rotate right
- 10 MUL: unsigned multiply, low WIDTH bits of a*b
- 11-15: illegal
REQ-014 Shift and rotate amounts SHALL be b[SHW-1:0]; upper bits of b SHALL be ignored.
REQ-015 A request SHALL be accepted on a rising edge where in_valid && in_ready; operands and opcode SHALL be captured at that edge, and later input changes SHALL have no effect on that operation.
REQ-016 The FSM SHALL have states IDLE, BUSY and DONE; reset state SHALL be IDLE.
REQ-017 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready), allowing back-to-back operations.
REQ-018 Accepting a non-MUL opcode SHALL register the result and flags at the accepting edge and enter DONE; out_valid SHALL be high in the following cycle (latency 1).
REQ-019 Accepting MUL SHALL enter BUSY and run an iterative shift-add over WIDTH cycles, one multiplier bit per cycle.
- After the WIDTH-th BUSY edge the FSM SHALL enter DONE.
- Latency from the accepting edge to out_valid SHALL be WIDTH+1 edges.
- in_ready SHALL be 0 throughout BUSY.
REQ-020 In DONE, out_valid SHALL be 1; alu_result and all flags SHALL hold stable until an edge where out_ready=1.
- If out_ready=1 and in_valid=1 at that edge, the new request SHALL be accepted (REQ-018/019).
- If out_ready=1 and in_valid=0, the FSM SHALL return to IDLE.
REQ-021 out_valid SHALL be 0 in IDLE and BUSY; alu_result and flags SHALL keep their last values there.
REQ-022 z SHALL equal ~|alu_result, and n SHALL equal alu_result[WIDTH-1], for every legal opcode.
REQ-023 v SHALL be computed per opcode:
- ADD/INC: set when the operand signs match and the result sign differs.
- SUB: set when the operand signs differ and the result sign differs from a.
- All other opcodes: 0.
REQ-024 c SHALL be computed per opcode:
- ADD/INC: carry out of bit WIDTH-1.
- SUB: borrow, i.e. 1 iff a<b unsigned.
- MUL: 1 iff the upper WIDTH product bits are nonzero.
- All other opcodes: 0.
REQ-025 An illegal opcode SHALL complete with latency 1, giving alu_result=0, err=1, z=1, and v=n=c=0; err SHALL be 0 for all legal opcodes.
REQ-026 A shift amount of 0 SHALL return a unchanged for SRA, SRL, SLL, ROL and ROR.
REQ-027 When in_valid is asserted while in_ready=0, the request SHALL be neither captured nor dropped; it stays pending until in_ready=1.

Reset
REQ-028 When rst=1 at an edge:
- state SHALL become IDLE;
- out_valid, alu_result, z, v, n, c and err SHALL become 0;
- in_ready SHALL be 1 in the following cycle;
- any in-progress MUL SHALL be abandoned with no result produced.
REQ-029 rst SHALL take priority over a simultaneous acceptance; no request SHALL be captured on a reset edge.

Verification (WIDTH=16)
REQ-030 Stimulus: ADD a=0x7FFF, b=0x0001. Response: out_valid exactly 1 cycle after acceptance, alu_result=0x8000, v=1, n=1, z=0, c=0.
REQ-031 Stimulus: MUL a=0x0012, b=0x0034. Response: in_ready=0 for 16 cycles, out_valid at acceptance+17 edges, alu_result=0x03A8, c=0. Then MUL 0x0100*0x0100 gives alu_result=0x0000, z=1, c=1.
REQ-032 Stimulus: SRA a=0x8000, b=0xFFF4. Response: alu_result=0xF800. Then ROR a=0x0001, b=0x0001 gives 0x8000. Then NAND a=0xFFFF, b=0x00FF gives 0xFF00.
REQ-033 Stimulus: SUB a=0x0003, b=0x0005 with out_ready held 0 for 5 cycles. Response: alu_result=0xFFFE, c=1, n=1, held stable with in_ready=0. Then on out_ready=1 with a pending XOR request, the XOR is accepted that same edge.
REQ-034 Stimulus: rst asserted 5 cycles into a MUL. Response: out_valid=0 and in_ready=1 the next cycle, and no MUL result ever appears.
REQ-035 Stimulus: opcode 0xC. Response: alu_result=0, err=1, z=1. A following legal ADD clears err to 0.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU behind a valid/ready handshake: single-cycle ops finish at the
// accepting edge, MUL runs an iterative shift-add over WIDTH cycles.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             z,
    output logic             v,
    output logic             n,
    output logic             c,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_NAND = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_INC  = 4'd4;
    localparam logic [3:0] OP_SRA  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8;
    localparam logic [3:0] OP_ROR  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_next;

    logic             accept;
    logic             is_mul;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] op_res;
    logic             op_v;
    logic             op_c;
    logic             op_err;

    logic [2*WIDTH-1:0] mul_acc;
    logic [2*WIDTH-1:0] mul_mcand;
    logic [2*WIDTH-1:0] mul_acc_next;
    logic [WIDTH-1:0]   mul_mplier;
    logic [SHW-1:0]     mul_cnt;
    logic               mul_last;

    assign in_ready     = (state == IDLE) || (state == DONE && out_ready);
    assign out_valid    = (state == DONE);
    assign accept       = in_valid && in_ready;
    assign is_mul       = (alu_op == OP_MUL);
    assign mul_last     = (mul_cnt == CNT_LAST);
    assign mul_acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = is_mul ? BUSY : DONE;
        end else if (state == BUSY && mul_last) begin
            state_next = DONE;
        end else if (state == DONE && out_ready) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first, so no latch is inferred.
        shamt  = alu_b[SHW-1:0];
        addend = (alu_op == OP_INC) ? WIDTH'(1) : alu_b;
        sum    = {1'b0, alu_a} + {1'b0, addend};
        diff   = {1'b0, alu_a} - {1'b0, alu_b};
        op_res = '0;
        op_v   = 1'b0;
        op_c   = 1'b0;
        op_err = 1'b0;
        case (alu_op)
            OP_ADD, OP_INC: begin
                op_res = sum[MSB:0];
                op_c   = sum[WIDTH];
                op_v   = (alu_a[MSB] == addend[MSB]) && (op_res[MSB] != alu_a[MSB]);
            end
            OP_SUB: begin
                op_res = diff[MSB:0];
                op_c   = diff[WIDTH];  // wraps into bit WIDTH exactly when a < b
                op_v   = (alu_a[MSB] != alu_b[MSB]) && (op_res[MSB] != alu_a[MSB]);
            end
            OP_NAND: op_res = ~(alu_a & alu_b);
            OP_XOR:  op_res = alu_a ^ alu_b;
            OP_SRA:  op_res = $signed(alu_a) >>> shamt;
            OP_SRL:  op_res = alu_a >> shamt;
            OP_SLL:  op_res = alu_a << shamt;
            OP_ROL:  op_res = (alu_a << shamt) | (alu_a >> (WIDTH - int'(shamt)));
            OP_ROR:  op_res = (alu_a >> shamt) | (alu_a << (WIDTH - int'(shamt)));
            OP_MUL:  op_res = '0;
            default: op_err = 1'b1;
        endcase
    end

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            alu_result <= '0;
            z          <= 1'b0;
            v          <= 1'b0;
            n          <= 1'b0;
            c          <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_next;
            if (accept && !is_mul) begin
                alu_result <= op_res;
                z          <= ~|op_res;
                n          <= op_res[MSB];
                v          <= op_v;
                c          <= op_c;
                err        <= op_err;
            end else if (state == BUSY && mul_last) begin
                alu_result <= mul_acc_next[MSB:0];
                z          <= ~|mul_acc_next[MSB:0];
                n          <= mul_acc_next[MSB];
                v          <= 1'b0;
                c          <= |mul_acc_next[2*WIDTH-1:WIDTH];
                err        <= 1'b0;
            end
        end
    end

    // NOTE: the multiplier datapath has no reset; it is always loaded on a MUL accept before use.
    always_ff @(posedge clk) begin
        if (accept && is_mul) begin
            mul_acc    <= '0;
            mul_mcand  <= {{WIDTH{1'b0}}, alu_a};
            mul_mplier <= alu_b;
            mul_cnt    <= '0;
        end else if (state == BUSY) begin
            mul_acc    <= mul_acc_next;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=16): arithmetic reference model with a
// per-cycle compare process, plus directed vectors with literal expectations.
module tb_seq_alu;

    localparam int W = 16;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_NAND = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_SRA  = 4'd5;
    localparam logic [3:0] OP_ROR  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef struct {
        logic [W-1:0] res;
        bit           z;
        bit           v;
        bit           n;
        bit           c;
        bit           err;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_result;
    logic         z, v, n, c, err;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   pend;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .z          (z),
        .v          (v),
        .n          (n),
        .c          (c),
        .err        (err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        longint       ua, ub, sa, sb, r, s, lim, half;
        int           sh;
        logic [W-1:0] t;
        e.res = '0; e.z = 0; e.v = 0; e.n = 0; e.c = 0; e.err = 0; e.due = 0;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        lim  = longint'(1) << W;
        half = longint'(1) << (W - 1);
        sh   = int'(ub % W);
        t    = a;
        case (op)
            4'd0: begin
                r = ua + ub; s = sa + sb;
                e.res = W'(r); e.c = (r >= lim); e.v = (s >= half) || (s < -half);
            end
            4'd1: begin
                r = ua - ub; s = sa - sb;
                e.res = W'(r); e.c = (ua < ub); e.v = (s >= half) || (s < -half);
            end
            4'd2: e.res = ~(a & b);
            4'd3: e.res = a ^ b;
            4'd4: begin
                r = ua + 1; s = sa + 1;
                e.res = W'(r); e.c = (r >= lim); e.v = (s >= half);
            end
            4'd5: e.res = W'(sa >>> sh);
            4'd6: e.res = W'(ua >> sh);
            4'd7: e.res = W'(ua << sh);
            4'd8: begin
                repeat (sh) t = {t[W-2:0], t[W-1]};
                e.res = t;
            end
            4'd9: begin
                repeat (sh) t = {t[0], t[W-1:1]};
                e.res = t;
            end
            4'd10: begin
                r = ua * ub;
                e.res = W'(r); e.c = (r >= lim);
            end
            default: e.err = 1;
        endcase
        e.z = (e.res == '0);
        e.n = e.res[W-1];
        return e;
    endfunction

    // Retire the model entry on the handshake edge, using pre-edge values.
    always @(posedge clk) begin
        if (!rst && exp_q.size() > 0 && cyc >= exp_q[0].due && out_ready)
            void'(exp_q.pop_front());
    end

    always @(negedge clk) begin
        if (!rst) begin
            pend = (exp_q.size() > 0) && (cyc >= exp_q[0].due);
            check("out_valid", 32'(out_valid), 32'(pend));
            check("in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || (pend && out_ready)));
            if (pend && out_valid) begin
                check("alu_result", 32'(alu_result), 32'(exp_q[0].res));
                check("flags_zvnc_err", 32'({z, v, n, c, err}),
                      32'({exp_q[0].z, exp_q[0].v, exp_q[0].n, exp_q[0].c, exp_q[0].err}));
            end
        end
    end

    // Present a request, wait for acceptance, record the model expectation, then scramble inputs.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int acc);
        exp_t e;
        int   k;
        #1;
        alu_op = op; alu_a = a; alu_b = b; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        acc   = cyc;
        e     = model(op, a, b);
        e.due = acc + ((op == OP_MUL) ? W : 0);
        exp_q.push_back(e);
        in_valid = 1'b0;
        alu_op   = ~op;
        alu_a    = ~a;
        alu_b    = b ^ 16'h5A5A;
    endtask

    task automatic wait_done(input int acc, output int lat, output int busy);
        lat  = 0;
        busy = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - acc + 1;
                return;
            end
            if (!in_ready) busy++;
        end
        check("done_timeout", 32'(out_valid), 32'd1);
    endtask

    logic [3:0]   t_op [16] = '{4'd4, 4'd4, 4'd1, 4'd0, 4'd0, 4'd7, 4'd6, 4'd5,
                                4'd8, 4'd8, 4'd9, 4'd10, 4'd15, 4'd2, 4'd3, 4'd6};
    logic [W-1:0] t_a  [16] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8000, 16'h0001,
                                16'h8000, 16'h8000, 16'h8001, 16'h8001, 16'h1234, 16'hFFFF,
                                16'hFFFF, 16'h0000, 16'hA5A5, 16'hF000};
    logic [W-1:0] t_b  [16] = '{16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h8000, 16'h000F,
                                16'h0010, 16'h000F, 16'h0001, 16'h0000, 16'h0014, 16'hFFFF,
                                16'hFFFF, 16'h0000, 16'hA5A5, 16'h0004};

    initial begin
        #200000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1);
    end

    initial begin
        int acc, lat, busy, vcount;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = '0; alu_a = '0; alu_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_result", 32'(alu_result), 32'd0);
        check("reset_flags", 32'({z, v, n, c, err}), 32'd0);

        // Signed overflow on ADD, latency 1.
        issue(OP_ADD, 16'h7FFF, 16'h0001, acc);
        wait_done(acc, lat, busy);
        check("add_latency", 32'(lat), 32'd1);
        check("add_result", 32'(alu_result), 32'h8000);
        check("add_vnzc", 32'({v, n, z, c}), 32'b1100);

        // Iterative multiply, then back-to-back multiply with a carry out.
        issue(OP_MUL, 16'h0012, 16'h0034, acc);
        wait_done(acc, lat, busy);
        check("mul_latency", 32'(lat), 32'd17);
        check("mul_busy_cycles", 32'(busy), 32'd16);
        check("mul_result", 32'(alu_result), 32'h03A8);
        check("mul_c", 32'(c), 32'd0);
        issue(OP_MUL, 16'h0100, 16'h0100, acc);
        wait_done(acc, lat, busy);
        check("mul2_latency", 32'(lat), 32'd17);
        check("mul2_result", 32'(alu_result), 32'h0000);
        check("mul2_zc", 32'({z, c}), 32'b11);

        issue(OP_SRA, 16'h8000, 16'hFFF4, acc);
        wait_done(acc, lat, busy);
        check("sra_result", 32'(alu_result), 32'hF800);
        issue(OP_ROR, 16'h0001, 16'h0001, acc);
        wait_done(acc, lat, busy);
        check("ror_result", 32'(alu_result), 32'h8000);
        issue(OP_NAND, 16'hFFFF, 16'h00FF, acc);
        wait_done(acc, lat, busy);
        check("nand_result", 32'(alu_result), 32'hFF00);

        // Result held under backpressure; a pending request goes in on the release edge.
        issue(OP_SUB, 16'h0003, 16'h0005, acc);
        out_ready = 1'b0;
        wait_done(acc, lat, busy);
        check("sub_latency", 32'(lat), 32'd1);
        check("sub_result", 32'(alu_result), 32'hFFFE);
        check("sub_cn", 32'({c, n}), 32'b11);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("sub_hold_result", 32'(alu_result), 32'hFFFE);
            check("sub_hold_in_ready", 32'(in_ready), 32'd0);
        end
        #1;
        alu_op = OP_XOR; alu_a = 16'h00FF; alu_b = 16'h0F0F; in_valid = 1'b1;
        @(negedge clk);
        check("xor_pending_blocked", 32'(in_ready), 32'd0);
        check("xor_pending_sub_held", 32'(alu_result), 32'hFFFE);
        #1 out_ready = 1'b1;
        issue(OP_XOR, 16'h00FF, 16'h0F0F, acc);
        wait_done(acc, lat, busy);
        check("xor_latency", 32'(lat), 32'd1);
        check("xor_result", 32'(alu_result), 32'h0FF0);

        // Reset five cycles into a multiply abandons it.
        issue(OP_MUL, 16'h1234, 16'h0003, acc);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mulrst_out_valid", 32'(out_valid), 32'd0);
        check("mulrst_in_ready", 32'(in_ready), 32'd1);
        check("mulrst_result", 32'(alu_result), 32'd0);
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("mulrst_no_result", 32'(vcount), 32'd0);

        // Reset beats a simultaneous acceptance.
        #1;
        rst = 1'b1; in_valid = 1'b1; alu_op = OP_ADD; alu_a = 16'h0005; alu_b = 16'h0006;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rstacc_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("rstacc_out_valid2", 32'(out_valid), 32'd0);
        check("rstacc_result", 32'(alu_result), 32'd0);

        // Illegal opcode, then a legal op clears err.
        issue(4'hC, 16'h1234, 16'h5678, acc);
        wait_done(acc, lat, busy);
        check("illegal_latency", 32'(lat), 32'd1);
        check("illegal_result", 32'(alu_result), 32'd0);
        check("illegal_err_z", 32'({err, z, v, n, c}), 32'b11000);
        issue(OP_ADD, 16'h0001, 16'h0002, acc);
        wait_done(acc, lat, busy);
        check("add_after_illegal_err", 32'(err), 32'd0);
        check("add_after_illegal_result", 32'(alu_result), 32'h0003);

        // Back-to-back table of boundary operands, checked by the model.
        for (int i = 0; i < 16; i++) issue(t_op[i], t_a[i], t_b[i], acc);
        for (int k = 0; k < 100 && exp_q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_in_ready", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
